// File: rtl/bcd_to_bin_pkg.sv
// Shared constants for the BCD-to-binary converter: state encoding,
// default sizing and BCD nibble width.
package bcd_to_bin_pkg;

  localparam int DEF_N_DIGITS = 4;
  localparam int DEF_BIN_W    = 14;
  localparam int NIB_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_sub3_adj.sv
// Reverse double-dabble correction for one BCD nibble: values >= 8 after
// the right shift had a 10 folded in from the digit above, so take 3 back.
module bcd_sub3_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);

  always_comb begin
    nib_out = nib_in;
    if (nib_in >= 4'd8) nib_out = nib_in - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double dabble), fixed latency
// of BIN_W shift cycles plus one DONE cycle per request.
//
// Handshake: start is sampled only in IDLE; busy is high for the SHIFT
// cycles; done pulses for one cycle when bin_out/err update. Requests seen
// while busy or in DONE are dropped, never queued.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int BIN_W    = DEF_BIN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NIB_W*N_DIGITS-1:0] bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err,
  output logic [1:0]                state_dbg
);

  localparam int BCD_W = NIB_W * N_DIGITS;
  localparam int RW    = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);

  state_t          state, next_state;
  logic [RW-1:0]   r;
  logic [RW-1:0]   r_shift;
  logic [RW-1:0]   r_next;
  logic [CW-1:0]   cnt;
  logic            inv;
  logic            any_bad;
  logic            last_iter;

  assign r_shift   = r >> 1;
  assign last_iter = (cnt == CW'(BIN_W - 1));
  assign r_next[BIN_W-1:0] = r_shift[BIN_W-1:0];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_sub3_adj u_adj (
      .nib_in  (r_shift[BIN_W + g*NIB_W +: NIB_W]),
      .nib_out (r_next [BIN_W + g*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[i*NIB_W +: NIB_W] > 4'd9) any_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SHIFT;
      ST_SHIFT: if (last_iter) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  // Invalid input still runs the full shift sequence so latency never varies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      cnt     <= '0;
      inv     <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            r   <= {bcd_in, {BIN_W{1'b0}}};
            inv <= any_bad;
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r   <= r_next;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            bin_out <= inv ? '0 : r_next[BIN_W-1:0];
            err     <= inv;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed scenarios plus random BCD words, checked
// every cycle against a timing/arithmetic reference model.
module tb_bcd_to_bin;

  localparam int BIN_W = 14;
  localparam int LAT   = 14;
  localparam int PERIOD_CONV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        busy, done, err;
  logic [BIN_W-1:0] bin_out;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;
  bit run_cmp = 1'b0;

  // reference model state
  logic [BIN_W:0] exp_q[$];
  int             m_timer = 0;
  logic [BIN_W-1:0] m_bin = '0;
  logic           m_err = 1'b0;

  bcd_to_bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [BIN_W:0] ref_conv(input logic [15:0] b);
    int val;
    bit bad;
    logic [15:0] t;
    t = b;
    val = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(t[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) return {1'b1, {BIN_W{1'b0}}};
    return {1'b0, BIN_W'(val)};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a request is taken whenever the converter is idle; its result
  // appears LAT cycles later and the block is free again one cycle after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timer <= 0;
      m_bin   <= '0;
      m_err   <= 1'b0;
      exp_q.delete();
    end else if (m_timer == 0) begin
      if (start) begin
        exp_q.push_back(ref_conv(bcd_in));
        m_timer <= LAT + 1;
      end
    end else begin
      m_timer <= m_timer - 1;
      if (m_timer == 2 && exp_q.size() > 0) begin
        m_bin <= exp_q[0][BIN_W-1:0];
        m_err <= exp_q[0][BIN_W];
        exp_q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      logic e_busy, e_done;
      e_busy = (m_timer >= 2);
      e_done = (m_timer == 1);
      checks++;
      if (busy !== e_busy || done !== e_done || bin_out !== m_bin || err !== m_err) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_cmp: busy=%b done=%b bin=%0d err=%b expected busy=%b done=%b bin=%0d err=%b at %0t",
                   busy, done, bin_out, err, e_busy, e_done, m_bin, m_err, $time);
        end
      end
    end
  end

  // Drive one request from idle and wait for its done pulse. glitch_at>=0
  // fires a second start (with new data) that many cycles into the run.
  task automatic do_conv(input logic [15:0] b, input int glitch_at,
                         output int res, output int res_err, output int lat,
                         output int nbusy);
    bit got;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    lat = 0;
    nbusy = 0;
    got = 1'b0;
    res = -1;
    res_err = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = (lat == glitch_at);
      if (lat == glitch_at) bcd_in = 16'h0007;
      if (done) begin
        got = 1'b1;
        res = int'(bin_out);
        res_err = int'(err);
        chk("busy_low_in_done", int'(busy), 0);
        break;
      end
      if (busy) nbusy++;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk);
  endtask

  int res, rerr, lat, nbusy, ndone, first_done, last_done;
  logic [15:0] rb;
  logic [BIN_W:0] rexp;

  initial begin
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_bin", int'(bin_out), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    do_conv(16'h9999, -1, res, rerr, lat, nbusy);
    chk("9999_val", res, 9999);
    chk("9999_err", rerr, 0);
    chk("9999_lat", lat, 14);
    chk("9999_busy_cycles", nbusy, 14);

    do_conv(16'h0000, -1, res, rerr, lat, nbusy);
    chk("0000_val", res, 0);
    chk("0000_err", rerr, 0);
    do_conv(16'h1234, -1, res, rerr, lat, nbusy);
    chk("1234_val", res, 1234);
    do_conv(16'h0010, -1, res, rerr, lat, nbusy);
    chk("0010_val", res, 10);

    do_conv(16'h12A4, -1, res, rerr, lat, nbusy);
    chk("12A4_err", rerr, 1);
    chk("12A4_val", res, 0);
    chk("12A4_lat", lat, 14);
    do_conv(16'h0005, -1, res, rerr, lat, nbusy);
    chk("0005_err", rerr, 0);
    chk("0005_val", res, 5);

    do_conv(16'h0500, 3, res, rerr, lat, nbusy);
    chk("ignored_start_val", res, 500);
    chk("ignored_start_lat", lat, 14);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_no_second_done", ndone, 0);

    // start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1;
    bcd_in = 16'h0042;
    ndone = 0;
    first_done = -1;
    last_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("held_val", int'(bin_out), 42);
        if (first_done < 0) first_done = c;
        last_done = c;
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 2);
    chk("held_interval", last_done - first_done, PERIOD_CONV);
    repeat (20) @(negedge clk);

    // async reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bcd_in = 16'h8765;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(bin_out), 0);
    chk("abort_err", int'(err), 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    #2;
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_conv(16'h0001, -1, res, rerr, lat, nbusy);
    chk("after_abort_val", res, 1);
    chk("after_abort_lat", lat, 14);

    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 7) == 0) rb[d*4 +: 4] = 4'($urandom_range(10, 15));
        else rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rexp = ref_conv(rb);
      do_conv(rb, -1, res, rerr, lat, nbusy);
      chk("rand_val", res, int'(rexp[BIN_W-1:0]));
      chk("rand_err", rerr, int'(rexp[BIN_W]));
      chk("rand_lat", lat, 14);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
